ram_prog_loader: RTL

- Sequences the program-load phase of the 8-bit CPU.
- While prog_mode is asserted, it accepts a byte stream from the external pins and writes the bytes into program RAM at consecutive addresses.
- It holds the CPU core (hlt path) for the whole load, then requests a one-cycle CPU restart when prog_mode is released.
- Sits between the top-level pin interface and the RAM write port, muxed ahead of the decoder-driven RAM control.

---
 rtl/ram_prog_loader_pkg.sv | 33 +++
 rtl/ram_prog_loader_if.sv | 36 +++
 rtl/ram_prog_loader_sum_acc.sv | 40 ++++
 rtl/ram_prog_loader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_prog_loader_pkg.sv
// Shared definitions for the program-load sequencer: default bus widths
// (also used by the program RAM and instruction decoder), the loader state
// encoding and the checksum add helper.
package ram_prog_loader_pkg;

    localparam int unsigned LOADER_ADDR_W = 4;
    localparam int unsigned LOADER_DATA_W = 8;
    localparam int unsigned LOADER_SUM_W  = 8;

    typedef enum logic [2:0] {
        LS_IDLE  = 3'd0,
        LS_RECV  = 3'd1,
        LS_WRITE = 3'd2,
        LS_CSUM  = 3'd3,
        LS_DONE  = 3'd4
    } loader_state_t;

    // Plain-vector state constants so the FSM register stays a logic vector
    localparam logic [2:0] ST_IDLE  = LS_IDLE;
    localparam logic [2:0] ST_RECV  = LS_RECV;
    localparam logic [2:0] ST_WRITE = LS_WRITE;
    localparam logic [2:0] ST_CSUM  = LS_CSUM;
    localparam logic [2:0] ST_DONE  = LS_DONE;

    // Modulo-256 running-sum step
    function automatic logic [LOADER_SUM_W-1:0] sum8_add(
        input logic [LOADER_SUM_W-1:0] acc,
        input logic [LOADER_SUM_W-1:0] din
    );
        return acc + din;
    endfunction

endpackage

// File: rtl/ram_prog_loader_if.sv
// Byte-stream input and RAM write port of the program loader.
// master: the loader (consumes the stream, drives the RAM write port).
// slave : the pin/RAM side (drives the stream, observes the write port).
interface ram_prog_loader_if
    import ram_prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = LOADER_ADDR_W,
    parameter int unsigned DATA_W = LOADER_DATA_W
) ();

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output ram_addr,
        output ram_wdata,
        output ram_we
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  ram_addr,
        input  ram_wdata,
        input  ram_we
    );

endinterface

// File: rtl/ram_prog_loader_sum_acc.sv
// loader_sum_acc: 8-bit modulo-256 accumulator with synchronous clear and
// add. Only instantiated when LOADER_CHECKSUM_EN is defined.
module loader_sum_acc
    import ram_prog_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    add,
    input  logic [LOADER_SUM_W-1:0] din,
    output logic [LOADER_SUM_W-1:0] sum
);

    logic [LOADER_SUM_W-1:0] sum_q;
    logic [LOADER_SUM_W-1:0] sum_d;

    // Next sum: clear wins over add, otherwise hold
    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = {LOADER_SUM_W{1'b0}};
        end else if (add) begin
            sum_d = sum8_add(sum_q, din);
        end else begin
            sum_d = sum_q;
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= {LOADER_SUM_W{1'b0}};
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/ram_prog_loader.sv
// ram_prog_loader: writes a byte stream into program RAM while prog_mode is
// high, holds the CPU for the whole load and requests a one-cycle CPU restart
// once prog_mode is released after a complete load.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing checksum byte check).
module ram_prog_loader
    import ram_prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W     = LOADER_ADDR_W,
    parameter int unsigned DATA_W     = LOADER_DATA_W,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned LAST_ADDR  = (2**ADDR_W) - 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_mode,
    ram_prog_loader_if.master  bus,
    output logic               cpu_hold,
    output logic               cpu_rst_req,
    output logic               load_done,
    output logic               checksum_err
);

    logic [2:0]        state_q,       state_d;
    logic              prog_mode_q,   prog_mode_d;
    logic              arm_q,         arm_d;
    logic [ADDR_W-1:0] ram_addr_q,    ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q,   ram_wdata_d;
    logic              in_ready_q,    in_ready_d;
    logic              ram_we_q,      ram_we_d;
    logic              cpu_hold_q,    cpu_hold_d;
    logic              cpu_rst_req_q, cpu_rst_req_d;
    logic              load_done_q,   load_done_d;
    logic              start_s;
    logic              handshake_s;
    logic              at_last_s;

    // arm_q blocks a false "edge" when prog_mode is already high as reset ends:
    // a load only starts after prog_mode has been seen low.
    assign start_s     = prog_mode & ~prog_mode_q & arm_q;
    assign handshake_s = bus.in_valid & in_ready_q;
    assign at_last_s   = (ram_addr_q == ADDR_W'(LAST_ADDR));

`ifdef LOADER_CHECKSUM_EN
    logic                    acc_clr_s;
    logic                    acc_add_s;
    logic [LOADER_SUM_W-1:0] acc_sum_s;
    logic                    checksum_err_q, checksum_err_d;

    loader_sum_acc u_sum_acc (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr_s),
        .add (acc_add_s),
        .din (bus.in_data[LOADER_SUM_W-1:0]),
        .sum (acc_sum_s)
    );
`endif

    // Next-state and next-output computation for the load sequencer
    always_comb begin
        state_d       = state_q;
        prog_mode_d   = prog_mode;
        arm_d         = arm_q | ~prog_mode;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        load_done_d   = load_done_q;
        cpu_rst_req_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        acc_clr_s      = 1'b0;
        acc_add_s      = 1'b0;
        checksum_err_d = checksum_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    ram_addr_d  = ADDR_W'(START_ADDR);
                    load_done_d = 1'b0;
                    state_d     = ST_RECV;
`ifdef LOADER_CHECKSUM_EN
                    acc_clr_s      = 1'b1;
                    checksum_err_d = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (!prog_mode) begin
                    state_d = ST_IDLE;
                end else if (handshake_s) begin
                    ram_wdata_d = bus.in_data;
                    state_d     = ST_WRITE;
`ifdef LOADER_CHECKSUM_EN
                    acc_add_s = 1'b1;
`endif
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_WRITE: begin
                // The strobe of this cycle is already registered, so an abort
                // here still completes the write.
                if (!prog_mode) begin
                    state_d = ST_IDLE;
                end else if (at_last_s) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = ST_CSUM;
`else
                    load_done_d = 1'b1;
                    state_d     = ST_DONE;
`endif
                end else begin
                    ram_addr_d = ram_addr_q + ADDR_W'(1);
                    state_d    = ST_RECV;
                end
            end
            ST_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                if (!prog_mode) begin
                    state_d = ST_IDLE;
                end else if (handshake_s) begin
                    checksum_err_d = (bus.in_data[LOADER_SUM_W-1:0] != acc_sum_s);
                    load_done_d    = 1'b1;
                    state_d        = ST_DONE;
                end else begin
                    state_d = ST_CSUM;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                if (!prog_mode) begin
                    cpu_rst_req_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are registered from the next state so they line up with it
        in_ready_d = (state_d == ST_RECV) || (state_d == ST_CSUM);
        ram_we_d   = (state_d == ST_WRITE);
        cpu_hold_d = (state_d != ST_IDLE);
    end

    // Sequencer and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            prog_mode_q   <= 1'b0;
            arm_q         <= ~prog_mode;
            ram_addr_q    <= ADDR_W'(START_ADDR);
            ram_wdata_q   <= {DATA_W{1'b0}};
            in_ready_q    <= 1'b0;
            ram_we_q      <= 1'b0;
            cpu_hold_q    <= 1'b0;
            cpu_rst_req_q <= 1'b0;
            load_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            prog_mode_q   <= prog_mode_d;
            arm_q         <= arm_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            in_ready_q    <= in_ready_d;
            ram_we_q      <= ram_we_d;
            cpu_hold_q    <= cpu_hold_d;
            cpu_rst_req_q <= cpu_rst_req_d;
            load_done_q   <= load_done_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Checksum result flag, sticky until the next start
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_err_q <= 1'b0;
        end else begin
            checksum_err_q <= checksum_err_d;
        end
    end

    assign checksum_err = checksum_err_q;
`else
    assign checksum_err = 1'b0;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_we    = ram_we_q;
    assign cpu_hold      = cpu_hold_q;
    assign cpu_rst_req   = cpu_rst_req_q;
    assign load_done     = load_done_q;

endmodule
